// File: rtl/nibble_serial_add_ctrl.sv
// Wide add/subtract built from one shared 4-bit ripple-carry slice, one nibble
// per clock, LSB nibble first, with a start/busy/done handshake.

module ripple_carry (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    always_comb begin
        logic c;
        c   = cin;
        sum = '0;
        for (int i = 0; i < 4; i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end
endmodule

module nibble_serial_add_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 sub,
    input  logic                 cin,
    input  logic [4*NIBBLES-1:0] op_a,
    input  logic [4*NIBBLES-1:0] op_b,
    output logic                 busy,
    output logic                 done,
    output logic [4*NIBBLES-1:0] result,
    output logic                 cout,
    output logic                 ovf
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   a_q, b_q;
    logic [W-1:0]   result_q;
    logic [IW-1:0]  idx_q;
    logic           carry_q;
    logic           cout_q;
    logic           ovf_q;

    logic [3:0]     slice_a, slice_b, slice_sum;
    logic           slice_cout;
    logic           last_nibble;
    logic           accept;

    // Two's-complement overflow: operands agree in sign, result sign differs.
    function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                        input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

    assign accept      = (state_q == IDLE) && start;
    assign last_nibble = (idx_q == IW'(NIBBLES - 1));

    always_comb begin
        slice_a = a_q[4*idx_q +: 4];
        slice_b = b_q[4*idx_q +: 4];
    end

    ripple_carry u_slice (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    // ---- state register ----
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---- next-state logic ----
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last_nibble) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---- output decode ----
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            RUN:     busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Operand capture; subtraction stores ~op_b so the slice always adds.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q <= op_a;
            b_q <= sub ? ~op_b : op_b;
        end
    end

    // ---- nibble sequencing and result registers ----
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q    <= '0;
            carry_q  <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        idx_q    <= '0;
                        carry_q  <= sub ? 1'b1 : cin;
                        result_q <= '0;
                        cout_q   <= 1'b0;
                        ovf_q    <= 1'b0;
                    end
                end
                RUN: begin
                    result_q[4*idx_q +: 4] <= slice_sum;
                    carry_q                <= slice_cout;
                    idx_q                  <= idx_q + IW'(1);
                    if (last_nibble) begin
                        cout_q <= slice_cout;
                        ovf_q  <= signed_ovf(a_q[W-1], b_q[W-1], slice_sum[3]);
                    end
                end
                default: ;
            endcase
        end
    end

    assign result = result_q;
    assign cout   = cout_q;
    assign ovf    = ovf_q;
endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Directed bench for nibble_serial_add_ctrl: a 4-nibble and a 2-nibble instance
// checked against hand-computed sums, latencies and handshake timing.

module tb_nibble_serial_add_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        start, sub, cin;
    logic [15:0] op_a, op_b, result;
    logic        busy, done, cout, ovf;

    logic        start2, sub2, cin2;
    logic [7:0]  op_a2, op_b2, result2;
    logic        busy2, done2, cout2, ovf2;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    nibble_serial_add_ctrl #(.NIBBLES(4)) dut4 (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .cin(cin),
        .op_a(op_a), .op_b(op_b), .busy(busy), .done(done),
        .result(result), .cout(cout), .ovf(ovf)
    );

    nibble_serial_add_ctrl #(.NIBBLES(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .sub(sub2), .cin(cin2),
        .op_a(op_a2), .op_b(op_b2), .busy(busy2), .done(done2),
        .result(result2), .cout(cout2), .ovf(ovf2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called at #1 after an edge with the DUT idle; returns in the same phase, idle again.
    task automatic run_op(input string tag, input logic s, input logic ci,
                          input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] er, input logic ec, input logic eo);
        op_a = a; op_b = b; sub = s; cin = ci; start = 1'b1;
        tick();
        start = 1'b0; op_a = ~a; op_b = ~b; sub = ~s; cin = ~ci;
        for (int i = 0; i < 4; i++) begin
            check({tag, "_busy"}, 32'(busy), 32'd1);
            check({tag, "_nodone"}, 32'(done), 32'd0);
            tick();
        end
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_busy_lo"}, 32'(busy), 32'd0);
        check({tag, "_result"}, 32'(result), 32'(er));
        check({tag, "_cout"}, 32'(cout), 32'(ec));
        check({tag, "_ovf"}, 32'(ovf), 32'(eo));
        tick();
        check({tag, "_done_1cyc"}, 32'(done), 32'd0);
        check({tag, "_hold"}, 32'(result), 32'(er));
    endtask

    initial begin
        int ndone;
        int both;
        rst = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0; op_a = '0; op_b = '0;
        start2 = 1'b0; sub2 = 1'b0; cin2 = 1'b0; op_a2 = '0; op_b2 = '0;
        tick();
        tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        rst = 1'b0;
        tick();

        run_op("add_basic", 1'b0, 1'b0, 16'h1234, 16'h0FFF, 16'h2233, 1'b0, 1'b0);
        run_op("add_wrap",  1'b0, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0);
        run_op("add_ovf",   1'b0, 1'b1, 16'h7FFF, 16'h0000, 16'h8000, 1'b0, 1'b1);
        run_op("sub_borrow", 1'b1, 1'b0, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0);
        run_op("sub_ovf",   1'b1, 1'b0, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1);

        // start held high; only operands present while idle are used
        op_a = 16'h0101; op_b = 16'h0202; sub = 1'b0; cin = 1'b0; start = 1'b1;
        tick();
        ndone = 0;
        both  = 0;
        for (int c = 0; c < 12; c++) begin
            if (busy && done) both++;
            if (done) begin
                ndone++;
                check("held_done_cyc", 32'(c), (ndone == 1) ? 32'd4 : 32'd10);
                check("held_result", 32'(result), (ndone == 1) ? 32'h0303 : 32'h8000);
            end
            op_a  = (c == 5) ? 16'h4000 : (16'hDEAD ^ 16'(c));
            op_b  = (c == 5) ? 16'h4000 : 16'hBEEF;
            start = (c < 10);
            tick();
        end
        check("held_ndone", 32'(ndone), 32'd2);
        check("held_never_both", 32'(both), 32'd0);

        // abort mid-run; outputs previously hold 0x8000 from the held-start test
        op_a = 16'h1234; op_b = 16'h0FFF; sub = 1'b0; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_result", 32'(result), 32'd0);
        check("abort_cout", 32'(cout), 32'd0);
        check("abort_ovf", 32'(ovf), 32'd0);
        rst = 1'b0;
        ndone = 0;
        for (int c = 0; c < 8; c++) begin
            if (done) ndone++;
            tick();
        end
        check("abort_no_done", 32'(ndone), 32'd0);
        run_op("after_abort", 1'b0, 1'b1, 16'h00FF, 16'h0F00, 16'h1000, 1'b0, 1'b0);

        // two-nibble instance
        op_a2 = 8'hFF; op_b2 = 8'h01; sub2 = 1'b0; cin2 = 1'b0; start2 = 1'b1;
        tick();
        start2 = 1'b0;
        check("n2_busy0", 32'(busy2), 32'd1);
        tick();
        check("n2_busy1", 32'(busy2), 32'd1);
        check("n2_nodone", 32'(done2), 32'd0);
        tick();
        check("n2_done", 32'(done2), 32'd1);
        check("n2_result", 32'(result2), 32'h00);
        check("n2_cout", 32'(cout2), 32'd1);
        check("n2_ovf", 32'(ovf2), 32'd0);
        tick();
        check("n2_done_1cyc", 32'(done2), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/nibble_serial_add_ctrl.md
Name: nibble_serial_add_ctrl

Overview:
- Sequencer that adds or subtracts two wide operands by reusing one 4-bit ripple-carry slice (module ripple_carry), one nibble per clock, LSB nibble first.
- Holds the carry between nibbles in a register, handles the start/busy/done handshake, and reports the result, carry-out and signed overflow.
- Sits between a requesting datapath block and the shared 4-bit adder slice, so wide arithmetic needs no wide adder.

Parameters:
- NIBBLES, 4, number of 4-bit slices per operand; operand width W = 4*NIBBLES; legal range 2..16.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request pulse/level; sampled only in IDLE.
- sub  input  1  0 = add, 1 = subtract (op_a - op_b); latched with start.
- cin  input  1  carry-in for add; ignored when sub=1; latched with start.
- op_a  input  W  operand A; latched with start.
- op_b  input  W  operand B; latched with start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse, result valid.
- result  output  W  sum/difference register.
- cout  output  1  final carry-out; for sub, 1 = no borrow.
- ovf  output  1  two's-complement signed overflow.

Behaviour:
- Reset is synchronous and active-high. rst high at a rising edge sets state=IDLE, idx=0, carry=0, and busy/done/result/cout/ovf all to 0. rst has priority over every other input, including mid-RUN, which aborts the operation with no done.
- Internal registers: a_q, b_q (W bits; b_q = op_b when sub=0, ~op_b when sub=1), sub_q, carry (1 bit), idx (ceil(log2(NIBBLES)) bits), state.
- States: IDLE, RUN, DONE.
- IDLE, start=1 at edge:
  - latch a_q, b_q, sub_q;
  - carry <= sub ? 1 : cin;
  - idx <= 0; result <= 0; cout <= 0; ovf <= 0;
  - go to RUN.
- IDLE, start=0: hold. Outputs keep the last completed result.
- RUN, each edge:
  - slice inputs are a_q[4*idx+:4], b_q[4*idx+:4], carry;
  - result[4*idx+:4] <= slice sum; carry <= slice cout; idx <= idx+1.
- RUN, on the edge where idx == NIBBLES-1:
  - cout <= slice cout;
  - ovf <= (a_q[W-1] == b_q[W-1]) && (slice sum[3] != a_q[W-1]);
  - go to DONE.
- DONE: done=1 for exactly this one cycle, then unconditionally to IDLE at the next edge.
- busy=1 in RUN only; done=1 in DONE only; never both high.
- Latency: if start is accepted at edge k, done is high in the cycle following edge k+NIBBLES. Initiation interval is NIBBLES+2 cycles; a new start is accepted no earlier than edge k+NIBBLES+2.
- start during RUN or DONE is ignored, not queued. Operand and sub changes after acceptance have no effect.
- result is partially updated during RUN and is only guaranteed valid while done=1 and afterwards in IDLE until the next accepted start.
- Arithmetic is modulo 2^W. Subtraction is a + ~b + 1. cout wraps naturally (0xFFFF+1 gives cout=1, result 0).
- The carry chain between nibbles is purely registered, so there is no combinational path from inputs to outputs.

Test Plan:
- NIBBLES=4, add, op_a=0x1234, op_b=0x0FFF, cin=0, start at edge k -> busy high for 4 cycles; done high in the cycle after edge k+4; result=0x2233, cout=0, ovf=0.
- Add 0xFFFF+0x0001, cin=0 -> result=0x0000, cout=1, ovf=0. Add 0x7FFF+0x0000 with cin=1 -> result=0x8000, cout=0, ovf=1.
- Sub 0x0005-0x0007 -> result=0xFFFE, cout=0 (borrow), ovf=0. Sub 0x8000-0x0001 -> result=0x7FFF, cout=1, ovf=1.
- Start held high continuously with changing operands -> only operands sampled in IDLE are used; operations complete every 6 cycles; exactly one done pulse per operation; mid-RUN operand changes do not affect result.
- Assert rst at edge k+2 of a running add -> next cycle busy=0, done=0, result=0, cout=0, ovf=0, state IDLE; no done pulse ever appears for the aborted operation; a following start completes normally.
- NIBBLES=2, add 0xFF+0x01 -> result=0x00, cout=1; done in the cycle after edge k+2.
